// File: rtl/xif_mem_responder.sv
// xif_mem_responder
//   Core-side responder for the CORE-V-XIF memory request/response and memory
//   result interfaces. Accepts one coprocessor load/store at a time, checks
//   alignment (and optionally a physical region), holds speculative stores
//   until commit, performs the access on an OBI-style data bus and returns a
//   single-cycle mem_result pulse.
//
//   Optional build macro: XIF_MEM_PMA_EN -- when defined, addresses outside
//   [PMA_BASE, PMA_BASE+PMA_SIZE) raise an access-fault exception at accept.
//
// Ports
//   ck, rst                 clock (rising edge), async active-low reset
//   mem_valid/mem_ready     request handshake
//   mem_req_*               request id, address, we, size, be, wdata, spec
//   mem_resp_exc/exccode    combinational exception response during accept
//   commit_valid/id/kill    commit strobe for held speculative stores
//   mem_result_*            result pulse with id, load data and bus error
//   data_*                  OBI-style bus (req/gnt, rvalid/rdata/err)
module xif_mem_responder #(
  parameter int unsigned         X_ID_WIDTH = 4,
  parameter int unsigned         XLEN       = 32,
  parameter logic [XLEN-1:0]     PMA_BASE   = 32'h0000_0000,
  parameter logic [XLEN-1:0]     PMA_SIZE   = 32'h0001_0000
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [X_ID_WIDTH-1:0] mem_req_id,
  input  logic [XLEN-1:0]       mem_req_addr,
  input  logic                  mem_req_we,
  input  logic [2:0]            mem_req_size,
  input  logic [3:0]            mem_req_be,
  input  logic [XLEN-1:0]       mem_req_wdata,
  input  logic                  mem_req_spec,
  output logic                  mem_resp_exc,
  output logic [5:0]            mem_resp_exccode,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  mem_result_valid,
  output logic [X_ID_WIDTH-1:0] mem_result_id,
  output logic [XLEN-1:0]       mem_result_rdata,
  output logic                  mem_result_err,
  output logic                  data_req,
  input  logic                  data_gnt,
  output logic [XLEN-1:0]       data_addr,
  output logic                  data_we,
  output logic [3:0]            data_be,
  output logic [XLEN-1:0]       data_wdata,
  input  logic                  data_rvalid,
  input  logic [XLEN-1:0]       data_rdata,
  input  logic                  data_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COMMIT,
    BUS_REQ,
    BUS_WAIT,
    RESULT
  } state_t;

  state_t state, state_nxt;

  logic [X_ID_WIDTH-1:0] id_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       rdata_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [1:0]            size_q;
  logic                  err_q;

  logic                  accept;
  logic                  exc_hit;
  logic [5:0]            exc_code;
  logic                  misaligned;
  logic [3:0]            lane_be;
  logic [XLEN-1:0]       rdata_shift;
  logic [XLEN-1:0]       rdata_mask;

  // Ready is qualified by rst so every output reads 0 while reset is held.
  assign mem_ready = (state == IDLE) && rst;
  assign accept    = mem_valid && mem_ready;

  assign misaligned = ((mem_req_size == 3'd1) && mem_req_addr[0]) ||
                      ((mem_req_size == 3'd2) && (mem_req_addr[1:0] != 2'b00));

  always_comb begin
    exc_hit  = 1'b0;
    exc_code = '0;
    if (mem_req_size > 3'd2) begin
      exc_hit  = 1'b1;
      exc_code = 6'd2;
    end else if (misaligned) begin
      exc_hit  = 1'b1;
      exc_code = mem_req_we ? 6'd6 : 6'd4;
    end
`ifdef XIF_MEM_PMA_EN
    // Offset compare wraps for addresses below PMA_BASE, so one test covers both bounds.
    else if ((mem_req_addr - PMA_BASE) >= PMA_SIZE) begin
      exc_hit  = 1'b1;
      exc_code = mem_req_we ? 6'd7 : 6'd5;
    end
`endif
  end

  assign mem_resp_exc     = accept && exc_hit;
  assign mem_resp_exccode = (accept && exc_hit) ? exc_code : '0;

  always_comb begin
    lane_be = 4'b1111;
    case (mem_req_size[1:0])
      2'd0:    lane_be = 4'b0001 << mem_req_addr[1:0];
      2'd1:    lane_be = 4'b0011 << mem_req_addr[1:0];
      default: lane_be = 4'b1111;
    endcase
  end

  assign rdata_shift = data_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rdata_mask = '1;
    case (size_q)
      2'd0:    rdata_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'd1:    rdata_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      default: rdata_mask = '1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !exc_hit)
          state_nxt = (mem_req_we && mem_req_spec) ? WAIT_COMMIT : BUS_REQ;
      end
      WAIT_COMMIT: begin
        if (commit_valid && (commit_id == id_q))
          state_nxt = commit_kill ? IDLE : BUS_REQ;
      end
      BUS_REQ:  if (data_gnt) state_nxt = BUS_WAIT;
      BUS_WAIT: if (data_rvalid) state_nxt = RESULT;
      RESULT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && !exc_hit) begin
        id_q    <= mem_req_id;
        addr_q  <= mem_req_addr;
        wdata_q <= mem_req_wdata;
        we_q    <= mem_req_we;
        be_q    <= lane_be & mem_req_be;
        size_q  <= mem_req_size[1:0];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if ((state == BUS_WAIT) && data_rvalid) begin
        rdata_q <= we_q ? '0 : (rdata_shift & rdata_mask);
        err_q   <= data_err;
      end
    end
  end

  assign data_req         = (state == BUS_REQ);
  assign data_addr        = {addr_q[XLEN-1:2], 2'b00};
  assign data_we          = we_q;
  assign data_be          = be_q;
  assign data_wdata       = wdata_q;

  assign mem_result_valid = (state == RESULT);
  assign mem_result_id    = id_q;
  assign mem_result_rdata = rdata_q;
  assign mem_result_err   = err_q;

endmodule

// File: tb/tb_xif_mem_responder.sv
// tb_xif_mem_responder
//   Directed bench for xif_mem_responder: loads of each size, committed and
//   killed speculative stores, non-speculative store with be masking,
//   exception codes, grant stalls with bus error, and reset mid-access.
module tb_xif_mem_responder;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_req_id = '0;
  logic [31:0] mem_req_addr = '0;
  logic        mem_req_we = 1'b0;
  logic [2:0]  mem_req_size = '0;
  logic [3:0]  mem_req_be = '0;
  logic [31:0] mem_req_wdata = '0;
  logic        mem_req_spec = 1'b0;
  logic        mem_resp_exc;
  logic [5:0]  mem_resp_exccode;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        mem_result_valid;
  logic [3:0]  mem_result_id;
  logic [31:0] mem_result_rdata;
  logic        mem_result_err;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        data_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  xif_mem_responder #(
    .X_ID_WIDTH (4),
    .XLEN       (32),
    .PMA_BASE   (32'h0000_0000),
    .PMA_SIZE   (32'h0001_0000)
  ) dut (
    .ck               (ck),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_req_id       (mem_req_id),
    .mem_req_addr     (mem_req_addr),
    .mem_req_we       (mem_req_we),
    .mem_req_size     (mem_req_size),
    .mem_req_be       (mem_req_be),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_spec     (mem_req_spec),
    .mem_resp_exc     (mem_resp_exc),
    .mem_resp_exccode (mem_resp_exccode),
    .commit_valid     (commit_valid),
    .commit_id        (commit_id),
    .commit_kill      (commit_kill),
    .mem_result_valid (mem_result_valid),
    .mem_result_id    (mem_result_id),
    .mem_result_rdata (mem_result_rdata),
    .mem_result_err   (mem_result_err),
    .data_req         (data_req),
    .data_gnt         (data_gnt),
    .data_addr        (data_addr),
    .data_we          (data_we),
    .data_be          (data_be),
    .data_wdata       (data_wdata),
    .data_rvalid      (data_rvalid),
    .data_rdata       (data_rdata),
    .data_err         (data_err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents one request for a single cycle at a negedge; returns at the
  // negedge after the accepting posedge.
  task automatic issue(input string tag, input logic [3:0] id, input logic [31:0] addr,
                       input logic we, input logic [2:0] size, input logic [3:0] be,
                       input logic [31:0] wdata, input logic spec,
                       input logic exp_exc, input logic [5:0] exp_code);
    @(negedge ck);
    mem_valid     = 1'b1;
    mem_req_id    = id;
    mem_req_addr  = addr;
    mem_req_we    = we;
    mem_req_size  = size;
    mem_req_be    = be;
    mem_req_wdata = wdata;
    mem_req_spec  = spec;
    #1;
    chk({tag, ".ready"}, {31'd0, mem_ready}, 32'd1);
    chk({tag, ".exc"}, {31'd0, mem_resp_exc}, {31'd0, exp_exc});
    chk({tag, ".exccode"}, {26'd0, mem_resp_exccode}, {26'd0, exp_code});
    @(negedge ck);
    mem_valid = 1'b0;
  endtask

  // Expects the DUT in BUS_REQ; stalls grant, then returns rvalid one cycle
  // after grant. Returns at the negedge where RESULT is expected.
  task automatic serve(input string tag, input int gnt_wait, input logic [31:0] rd,
                       input logic e, input logic [31:0] exp_addr, input logic exp_we,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    chk({tag, ".req"}, {31'd0, data_req}, 32'd1);
    chk({tag, ".addr"}, data_addr, exp_addr);
    chk({tag, ".we"}, {31'd0, data_we}, {31'd0, exp_we});
    chk({tag, ".be"}, {28'd0, data_be}, {28'd0, exp_be});
    chk({tag, ".wdata"}, data_wdata, exp_wdata);
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge ck);
      chk({tag, ".req_hold"}, {31'd0, data_req}, 32'd1);
      chk({tag, ".addr_hold"}, data_addr, exp_addr);
    end
    data_gnt = 1'b1;
    @(negedge ck);
    data_gnt = 1'b0;
    chk({tag, ".req_drop"}, {31'd0, data_req}, 32'd0);
    data_rvalid = 1'b1;
    data_rdata  = rd;
    data_err    = e;
    @(negedge ck);
    data_rvalid = 1'b0;
    data_rdata  = '0;
    data_err    = 1'b0;
  endtask

  task automatic result(input string tag, input logic [3:0] id, input logic [31:0] rdata,
                        input logic err);
    chk({tag, ".rvalid"}, {31'd0, mem_result_valid}, 32'd1);
    chk({tag, ".rid"}, {28'd0, mem_result_id}, {28'd0, id});
    chk({tag, ".rdata"}, mem_result_rdata, rdata);
    chk({tag, ".rerr"}, {31'd0, mem_result_err}, {31'd0, err});
    @(negedge ck);
    chk({tag, ".rvalid_pulse"}, {31'd0, mem_result_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, mem_ready}, 32'd1);
  endtask

  task automatic no_access(input string tag);
    chk({tag, ".no_req"}, {31'd0, data_req}, 32'd0);
    chk({tag, ".no_result"}, {31'd0, mem_result_valid}, 32'd0);
    chk({tag, ".ready_idle"}, {31'd0, mem_ready}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst.ready", {31'd0, mem_ready}, 32'd0);
    chk("rst.req", {31'd0, data_req}, 32'd0);
    chk("rst.rvalid", {31'd0, mem_result_valid}, 32'd0);
    chk("rst.addr", data_addr, 32'd0);
    chk("rst.exc", {31'd0, mem_resp_exc}, 32'd0);
    @(negedge ck);
    rst = 1'b1;
    #1;
    chk("rst.ready_release", {31'd0, mem_ready}, 32'd1);

    // Load word, minimum latency: accept, BUS_REQ, BUS_WAIT, RESULT.
    issue("lw", 4'd3, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0, 1'b1, 1'b0, 6'd0);
    serve("lw", 0, 32'hDEADBEEF, 1'b0, 32'h100, 1'b0, 4'hF, 32'h0);
    result("lw", 4'd3, 32'hDEADBEEF, 1'b0);

    issue("lb", 4'd1, 32'h103, 1'b0, 3'd0, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    serve("lb", 0, 32'h11223344, 1'b0, 32'h100, 1'b0, 4'b1000, 32'h0);
    result("lb", 4'd1, 32'h00000011, 1'b0);

    issue("lh", 4'd2, 32'h302, 1'b0, 3'd1, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    serve("lh", 0, 32'h11223344, 1'b0, 32'h300, 1'b0, 4'b1100, 32'h0);
    result("lh", 4'd2, 32'h00001122, 1'b0);

    // Speculative store held until its own id commits.
    issue("sw", 4'd5, 32'h200, 1'b1, 3'd2, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      chk("sw.hold_req", {31'd0, data_req}, 32'd0);
      @(negedge ck);
    end
    commit_valid = 1'b1;
    commit_id    = 4'd4;
    commit_kill  = 1'b0;
    @(negedge ck);
    chk("sw.other_id", {31'd0, data_req}, 32'd0);
    commit_id = 4'd5;
    @(negedge ck);
    commit_valid = 1'b0;
    serve("sw", 0, 32'h12345678, 1'b0, 32'h200, 1'b1, 4'hF, 32'hCAFEF00D);
    result("sw", 4'd5, 32'h0, 1'b0);

    issue("swk", 4'd5, 32'h200, 1'b1, 3'd2, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 6'd0);
    commit_valid = 1'b1;
    commit_id    = 4'd5;
    commit_kill  = 1'b1;
    @(negedge ck);
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    no_access("swk");

    // Non-speculative store goes straight to the bus; be is masked by lanes.
    issue("swm", 4'd6, 32'h204, 1'b1, 3'd2, 4'b0101, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0);
    serve("swm", 0, 32'hFFFFFFFF, 1'b0, 32'h204, 1'b1, 4'b0101, 32'hA5A5A5A5);
    result("swm", 4'd6, 32'h0, 1'b0);

    issue("exc_lw", 4'd1, 32'h102, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b1, 6'd4);
    no_access("exc_lw");
    issue("exc_sh", 4'd1, 32'h201, 1'b1, 3'd1, 4'hF, 32'h0, 1'b0, 1'b1, 6'd6);
    no_access("exc_sh");
    issue("exc_sz", 4'd1, 32'h101, 1'b0, 3'd3, 4'hF, 32'h0, 1'b0, 1'b1, 6'd2);
    no_access("exc_sz");

    // Grant stalled four cycles, then a bus error.
    issue("stall", 4'd7, 32'h300, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    serve("stall", 4, 32'hAAAAAAAA, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0);
    result("stall", 4'd7, 32'hAAAAAAAA, 1'b1);

    // Reset asserted while waiting for rvalid.
    issue("rmid", 4'd9, 32'h400, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    chk("rmid.req", {31'd0, data_req}, 32'd1);
    data_gnt = 1'b1;
    @(negedge ck);
    data_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmid.req0", {31'd0, data_req}, 32'd0);
    chk("rmid.ready0", {31'd0, mem_ready}, 32'd0);
    chk("rmid.addr0", data_addr, 32'd0);
    chk("rmid.be0", {28'd0, data_be}, 32'd0);
    chk("rmid.rid0", {28'd0, mem_result_id}, 32'd0);
    @(negedge ck);
    rst = 1'b1;
    #1;
    chk("rmid.ready1", {31'd0, mem_ready}, 32'd1);
    @(negedge ck);
    no_access("rmid");

`ifdef XIF_MEM_PMA_EN
    issue("pma_ld", 4'd2, 32'h0001_0000, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b1, 6'd5);
    no_access("pma_ld");
    issue("pma_st", 4'd2, 32'h0001_0000, 1'b1, 3'd2, 4'hF, 32'h0, 1'b0, 1'b1, 6'd7);
    no_access("pma_st");
    issue("pma_in", 4'd8, 32'h0000_FFFC, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    serve("pma_in", 0, 32'h01020304, 1'b0, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0);
    result("pma_in", 4'd8, 32'h01020304, 1'b0);
`else
    issue("nopma", 4'd8, 32'h0001_0000, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, 6'd0);
    serve("nopma", 0, 32'h01020304, 1'b0, 32'h0001_0000, 1'b0, 4'hF, 32'h0);
    result("nopma", 4'd8, 32'h01020304, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run expected completion");
    $fatal(1, "timeout");
  end

endmodule
